hazard_stall_ctrl: RTL and testbench

- Pipeline hazard and stall sequencer for the 5-stage ARM core.
- Decides per cycle whether IF/ID stalls for a data hazard, whether the whole pipeline freezes for a slow data-memory access, and when to flush on a taken branch.
- Drives the enable input of the forwarding unit, so forwarding and stalling policy live in one place.
- Sits beside the ID stage; inputs come from the ID, EXE and MEM stage registers and the SRAM controller.

---
 rtl/hazard_stall_ctrl.sv | 170 +++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: hazard and stall sequencer for the 5-stage ARM pipeline.
// Decides per cycle whether IF/ID stalls for a RAW hazard, whether the whole
// pipeline freezes while data memory is slow, and when to flush on a taken
// branch. Also drives the forwarding-unit enable.
// Optional build macro: HAZARD_STATS_EN adds freeze_cnt and flush_cnt outputs.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_mode,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             two_src,
    input  logic             ID_valid,
    input  logic [3:0]       EXE_Dest,
    input  logic             EXE_WB_en,
    input  logic             EXE_MEM_R_en,
    input  logic [3:0]       MEM_Dest,
    input  logic             MEM_WB_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             fwd_en,
    output logic             hazard_stall,
    output logic             freeze_all,
    output logic             flush,
    output logic             mem_err,
`ifdef HAZARD_STATS_EN
    output logic [CNT_W-1:0] freeze_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic [CNT_W-1:0] stall_cnt
);

    // Wide enough to hold MEM_TIMEOUT-1 for any timeout value.
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic m1, m2, n1, n2;
    logic hz;
    logic freeze_raw;

    // RAW hazard detection against the EXE and MEM destination registers.
    always_comb begin
        m1 = EXE_WB_en && (src1 == EXE_Dest);
        m2 = EXE_WB_en && two_src && (src2 == EXE_Dest);
        n1 = MEM_WB_en && (src1 == MEM_Dest);
        n2 = MEM_WB_en && two_src && (src2 == MEM_Dest);
        hz = 1'b0;
        if (ID_valid) begin
            // With forwarding only a load-use in EXE cannot be bypassed.
            hz = fwd_mode ? (EXE_MEM_R_en && (m1 || m2)) : (m1 || m2 || n1 || n2);
        end
    end

    // Memory-wait FSM: next state, wait counter, sticky error and raw freeze.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        freeze_raw = 1'b0;
        unique case (state_q)
            IDLE: begin
                freeze_raw = mem_req && !mem_ready;
                if (mem_req && !mem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                // Release in the same cycle mem_ready arrives.
                freeze_raw = !mem_ready;
                if (mem_ready) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_END) begin
                    state_d   = ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ERR: begin
                freeze_raw = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output priority: freeze beats flush, flush beats hazard stall; all low in reset.
    always_comb begin
        fwd_en       = fwd_mode && !rst;
        freeze_all   = freeze_raw && !rst;
        flush        = branch_taken && !freeze_all && !rst;
        hazard_stall = hz && !freeze_all && !branch_taken && !rst;
        stall_cnt_d  = stall_cnt_q;
        if (hazard_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating freeze and flush statistics.
    always_comb begin
        freeze_cnt_d = freeze_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (freeze_all && (freeze_cnt_q != CNT_MAX)) begin
            freeze_cnt_d = freeze_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            freeze_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            freeze_cnt_q <= freeze_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign freeze_cnt = freeze_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl (MEM_TIMEOUT=4, CNT_W=4 build).
module tb_hazard_stall_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             fwd_mode;
    logic [3:0]       src1, src2;
    logic             two_src, ID_valid;
    logic [3:0]       EXE_Dest;
    logic             EXE_WB_en, EXE_MEM_R_en;
    logic [3:0]       MEM_Dest;
    logic             MEM_WB_en;
    logic             mem_req, mem_ready, branch_taken;
    logic             fwd_en, hazard_stall, freeze_all, flush, mem_err;
    logic [CNT_W-1:0] stall_cnt;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] freeze_cnt, flush_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .fwd_mode     (fwd_mode),
        .src1         (src1),
        .src2         (src2),
        .two_src      (two_src),
        .ID_valid     (ID_valid),
        .EXE_Dest     (EXE_Dest),
        .EXE_WB_en    (EXE_WB_en),
        .EXE_MEM_R_en (EXE_MEM_R_en),
        .MEM_Dest     (MEM_Dest),
        .MEM_WB_en    (MEM_WB_en),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .fwd_en       (fwd_en),
        .hazard_stall (hazard_stall),
        .freeze_all   (freeze_all),
        .flush        (flush),
        .mem_err      (mem_err),
`ifdef HAZARD_STATS_EN
        .freeze_cnt   (freeze_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .stall_cnt    (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and step just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        fwd_mode     = 1'b0;
        src1         = 4'd0;
        src2         = 4'd0;
        two_src      = 1'b0;
        ID_valid     = 1'b0;
        EXE_Dest     = 4'd0;
        EXE_WB_en    = 1'b0;
        EXE_MEM_R_en = 1'b0;
        MEM_Dest     = 4'd0;
        MEM_WB_en    = 1'b0;
        mem_req      = 1'b0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic set_exe_hazard();
        ID_valid  = 1'b1;
        src1      = 4'd3;
        EXE_Dest  = 4'd3;
        EXE_WB_en = 1'b1;
    endtask

    initial begin
        // Reset with every input trying to assert something.
        rst = 1'b1;
        clear_in();
        fwd_mode = 1'b1;
        set_exe_hazard();
        mem_req      = 1'b1;
        branch_taken = 1'b1;
        tick();
        tick();
        check("rst_fwd_en", fwd_en, 0);
        check("rst_hazard", hazard_stall, 0);
        check("rst_freeze", freeze_all, 0);
        check("rst_flush", flush, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_stall_cnt", stall_cnt, 0);

        // EXE match without forwarding.
        rst = 1'b0;
        clear_in();
        set_exe_hazard();
        #1;
        check("nofwd_exe_hz", hazard_stall, 1);
        check("nofwd_fwd_en", fwd_en, 0);
        check("cnt_before", stall_cnt, 0);
        tick();
        check("cnt_after_1", stall_cnt, 1);
        ID_valid = 1'b0;
        #1;
        check("id_invalid", hazard_stall, 0);

        // MEM match on src2 (R15) depends on two_src.
        clear_in();
        ID_valid  = 1'b1;
        src2      = 4'd15;
        MEM_Dest  = 4'd15;
        MEM_WB_en = 1'b1;
        #1;
        check("mem_src2_one_src", hazard_stall, 0);
        two_src = 1'b1;
        #1;
        check("mem_src2_two_src", hazard_stall, 1);
        tick();
        check("cnt_after_2", stall_cnt, 2);

        // R0 match only when EXE writes back.
        clear_in();
        ID_valid = 1'b1;
        #1;
        check("r0_no_wb", hazard_stall, 0);
        EXE_WB_en = 1'b1;
        #1;
        check("r0_wb", hazard_stall, 1);

        // Forwarding: only load-use stalls.
        clear_in();
        fwd_mode = 1'b1;
        set_exe_hazard();
        #1;
        check("fwd_alu_hz", hazard_stall, 0);
        check("fwd_en_on", fwd_en, 1);
        EXE_MEM_R_en = 1'b1;
        #1;
        check("fwd_load_use", hazard_stall, 1);
        tick();
        check("cnt_after_3", stall_cnt, 3);
        clear_in();
        fwd_mode     = 1'b1;
        ID_valid     = 1'b1;
        src1         = 4'd5;
        MEM_Dest     = 4'd5;
        MEM_WB_en    = 1'b1;
        EXE_Dest     = 4'd6;
        EXE_WB_en    = 1'b1;
        EXE_MEM_R_en = 1'b1;
        #1;
        check("fwd_mem_match", hazard_stall, 0);

        // Memory wait: 3 frozen cycles, release with pending branch.
        clear_in();
        set_exe_hazard();
        mem_req = 1'b1;
        #1;
        check("mw_c1_freeze", freeze_all, 1);
        check("mw_c1_hz", hazard_stall, 0);
        tick();
        branch_taken = 1'b1;
        #1;
        check("mw_c2_freeze", freeze_all, 1);
        check("mw_c2_flush", flush, 0);
        check("mw_c2_hz", hazard_stall, 0);
        tick();
        check("mw_c3_freeze", freeze_all, 1);
        tick();
        mem_ready = 1'b1;
        #1;
        check("mw_c4_freeze", freeze_all, 0);
        check("mw_c4_flush", flush, 1);
        check("mw_c4_hz", hazard_stall, 0);
        check("mw_c4_err", mem_err, 0);
        tick();
        clear_in();
        #1;
        check("mw_back_idle", freeze_all, 0);
        check("mw_stall_cnt", stall_cnt, 3);
`ifdef HAZARD_STATS_EN
        check("mw_freeze_cnt", freeze_cnt, 3);
        check("mw_flush_cnt", flush_cnt, 1);
`endif
        mem_req   = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("idle_ready_now", freeze_all, 0);
        tick();
        mem_req   = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("idle_stays", freeze_all, 0);

        // Timeout into ERR after the 4th wait edge.
        mem_req = 1'b1;
        tick();
        tick();
        tick();
        check("to_e3_err", mem_err, 0);
        check("to_e3_freeze", freeze_all, 1);
        tick();
        check("to_e4_err", mem_err, 1);
        mem_req = 1'b0;
        #1;
        check("err_freeze", freeze_all, 1);
        mem_ready = 1'b1;
        set_exe_hazard();
        branch_taken = 1'b1;
        #1;
        check("err_ignores_ready", freeze_all, 1);
        check("err_hz", hazard_stall, 0);
        check("err_flush", flush, 0);
        tick();
        tick();
        check("err_sticky", mem_err, 1);
        check("err_stall_cnt", stall_cnt, 3);
        rst = 1'b1;
        #1;
        check("rst_hi_freeze", freeze_all, 0);
        check("rst_hi_err_reg", mem_err, 1);
        tick();
        rst = 1'b0;
        clear_in();
        #1;
        check("post_rst_err", mem_err, 0);
        check("post_rst_freeze", freeze_all, 0);
        check("post_rst_cnt", stall_cnt, 0);
`ifdef HAZARD_STATS_EN
        check("post_rst_freeze_cnt", freeze_cnt, 0);
        check("post_rst_flush_cnt", flush_cnt, 0);
`endif

        // Saturation of the 4-bit stall counter.
        set_exe_hazard();
        repeat (14) tick();
        check("sat_14", stall_cnt, 14);
        tick();
        check("sat_15", stall_cnt, 15);
        repeat (3) tick();
        check("sat_hold", stall_cnt, 15);
        check("sat_hz_still", hazard_stall, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
